// File: rtl/spike_popcount_acc_pkg.sv
// Shared constants, window state encoding and adder-tree geometry helpers
// for the spike popcount accumulator.
package spike_popcount_acc_pkg;

    localparam int DEF_NUM_IN = 16;
    localparam int DEF_ACC_W  = 12;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int TREE_STAGES = clog2(DEF_NUM_IN);

    // Stage k of the tree produces (k+1)-bit sums; stage 0 is the raw spike bits.
    function automatic int stage_w(input int k);
        return k + 1;
    endfunction

    function automatic int stage_bits(input int num_in, input int k);
        return (num_in >> k) * stage_w(k);
    endfunction

    // Bit offset of stage k inside the flat tree bus holding stages 0..L.
    function automatic int stage_off(input int num_in, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) off += stage_bits(num_in, j);
        return off;
    endfunction

    typedef enum logic {
        WIN_IDLE = 1'b0,
        WIN_OPEN = 1'b1
    } win_state_e;

endpackage

// File: rtl/spike_popcount_acc_if.sv
// Beat input and window-result output bundle of the spike popcount accumulator.
interface spike_popcount_acc_if
    import spike_popcount_acc_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              i_spike_valid;
    logic [NUM_IN-1:0] i_spikes;
    logic              i_last;
    logic              o_count_valid;
    logic [ACC_W-1:0]  o_count;
    logic              o_sat;

    modport master (
        output i_spike_valid, i_spikes, i_last,
        input  o_count_valid, o_count, o_sat
    );

    modport slave (
        input  i_spike_valid, i_spikes, i_last,
        output o_count_valid, o_count, o_sat
    );
endinterface

// File: rtl/spike_popcount_acc_adder_tree_stage.sv
// One registered level of the popcount tree: pairwise sums of IN_W-bit operands,
// half adders at the 1-bit leaves, plus the valid/last sideband.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module adder_tree_stage
    import spike_popcount_acc_pkg::*;
#(
    parameter int IN_W    = 1,
    parameter int N_PAIRS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic [2*N_PAIRS*IN_W-1:0]        in_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic [N_PAIRS*stage_w(IN_W)-1:0] out_data
);
    localparam int OUT_W = stage_w(IN_W);

    logic [N_PAIRS*OUT_W-1:0] sum;

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        if (IN_W == 1) begin : g_leaf
            half_adder u_ha (
                .a(in_data[2*p]),
                .b(in_data[2*p+1]),
                .s(sum[2*p]),
                .c(sum[2*p+1])
            );
        end else begin : g_wide
            assign sum[p*OUT_W +: OUT_W] = {1'b0, in_data[2*p*IN_W +: IN_W]}
                                         + {1'b0, in_data[(2*p+1)*IN_W +: IN_W]};
        end
    end

    // NOTE: non-blocking (<=) for every register so all stages sample the
    // pre-edge values together; blocking here would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_last;
        end
        // NOTE: the sum registers are deliberately not reset; they are only
        // consumed when the matching valid bit is set, which reset does clear.
        out_data <= sum;
    end
endmodule

// File: rtl/spike_popcount_acc.sv
// Pipelined spike popcount: log2(NUM_IN) registered adder-tree stages followed
// by a saturating window accumulator that emits one count per i_last-closed window.
module spike_popcount_acc
    import spike_popcount_acc_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int ACC_W  = DEF_ACC_W
) (
    input logic                 s_clk,
    input logic                 s_rst,
    spike_popcount_acc_if.slave bus
);
    localparam int L      = clog2(NUM_IN);
    localparam int POP_W  = stage_w(L);
    localparam int TREE_W = stage_off(NUM_IN, L + 1);

    // Stages 0..L packed back to back; stage 0 is the incoming spike vector.
    logic [TREE_W-1:0] tree_data;
    logic [L:0]        tree_valid;
    logic [L:0]        tree_last;

    assign tree_data[0 +: NUM_IN] = bus.i_spikes;
    assign tree_valid[0]          = bus.i_spike_valid;
    assign tree_last[0]           = bus.i_last;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        adder_tree_stage #(
            .IN_W   (k),
            .N_PAIRS(NUM_IN >> k)
        ) u_stage (
            .clk      (s_clk),
            .rst      (s_rst),
            .in_valid (tree_valid[k-1]),
            .in_last  (tree_last[k-1]),
            .in_data  (tree_data[stage_off(NUM_IN, k-1) +: stage_bits(NUM_IN, k-1)]),
            .out_valid(tree_valid[k]),
            .out_last (tree_last[k]),
            .out_data (tree_data[stage_off(NUM_IN, k) +: stage_bits(NUM_IN, k)])
        );
    end

    logic [POP_W-1:0] pop;
    logic             pop_valid;
    logic             pop_last;

    assign pop       = tree_data[stage_off(NUM_IN, L) +: POP_W];
    assign pop_valid = tree_valid[L];
    assign pop_last  = tree_last[L];

    win_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, base;
    logic             sat_q, sat_d, sat_base;
    logic [ACC_W:0]   sum;
    logic             count_valid_q, sat_out_q;
    logic [ACC_W-1:0] count_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        base     = '0;
        sat_base = 1'b0;
        // A closed window restarts from zero with a clean saturation flag.
        if (state_q == WIN_OPEN) begin
            base     = acc_q;
            sat_base = sat_q;
        end
        sum   = {1'b0, base} + {{(ACC_W + 1 - POP_W){1'b0}}, pop};
        acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        sat_d = sat_base | sum[ACC_W];
        if (pop_valid) state_d = pop_last ? WIN_IDLE : WIN_OPEN;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q       <= WIN_IDLE;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            count_valid_q <= 1'b0;
            count_q       <= '0;
            sat_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_valid_q <= pop_valid & pop_last;
            if (pop_valid) begin
                acc_q <= acc_d;
                sat_q <= sat_d;
                if (pop_last) begin
                    count_q   <= acc_d;
                    sat_out_q <= sat_d;
                end
            end
        end
    end

    assign bus.o_count_valid = count_valid_q;
    assign bus.o_count       = count_q;
    assign bus.o_sat         = sat_out_q;
endmodule
